// File: rtl/alu_issue_dec.sv
// MIPS-I decode stage feeding the ALU: decodes one instruction per cycle
// into an EXE op code plus operands, held in a handshaked ID/EX register.
module alu_issue_dec #(
    parameter int IMM_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  op,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic        wreg,
    output logic [4:0]  waddr,
    output logic        illegal
);

    localparam logic [7:0] EXE_NOP_OP  = 8'b00000000;
    localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
    localparam logic [7:0] EXE_ANDI_OP = 8'b01011001;
    localparam logic [7:0] EXE_ORI_OP  = 8'b01011010;
    localparam logic [7:0] EXE_XORI_OP = 8'b01011011;
    localparam logic [7:0] EXE_LUI_OP  = 8'b01011100;
    localparam logic [7:0] EXE_SLT_OP  = 8'b00101010;
    localparam logic [7:0] EXE_ADD_OP  = 8'b00100000;
    localparam logic [7:0] EXE_SUB_OP  = 8'b00100010;
    localparam logic [7:0] EXE_ADDI_OP = 8'b01010101;
    localparam logic [7:0] EXE_BEQ_OP  = 8'b01010001;
    localparam logic [7:0] EXE_LW_OP   = 8'b11100011;
    localparam logic [7:0] EXE_SW_OP   = 8'b11101011;

    localparam logic [5:0] OPC_SPECIAL = 6'b000000;
    localparam logic [5:0] OPC_ADDI    = 6'b001000;
    localparam logic [5:0] OPC_ANDI    = 6'b001100;
    localparam logic [5:0] OPC_ORI     = 6'b001101;
    localparam logic [5:0] OPC_XORI    = 6'b001110;
    localparam logic [5:0] OPC_LUI     = 6'b001111;
    localparam logic [5:0] OPC_LW      = 6'b100011;
    localparam logic [5:0] OPC_SW      = 6'b101011;
    localparam logic [5:0] OPC_BEQ     = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [4:0]       rt_f;
    logic [4:0]       rd_f;
    logic [IMM_W-1:0] imm;
    logic [31:0]      sext;
    logic [31:0]      zext;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rt_f   = instr[20:16];
    assign rd_f   = instr[15:11];
    assign imm    = instr[IMM_W-1:0];
    assign sext   = {{(32-IMM_W){imm[IMM_W-1]}}, imm};
    assign zext   = {{(32-IMM_W){1'b0}}, imm};

    logic [7:0]  d_op;
    logic [31:0] d_a;
    logic [31:0] d_b;
    logic        d_wreg;
    logic [4:0]  d_waddr;
    logic        d_illegal;

    always_comb begin
        d_op      = EXE_NOP_OP;
        d_a       = rs_data;
        d_b       = rt_data;
        d_wreg    = 1'b0;
        d_waddr   = 5'd0;
        d_illegal = 1'b0;
        if (instr != 32'd0) begin
            case (opcode)
                OPC_SPECIAL: begin
                    d_wreg  = 1'b1;
                    d_waddr = rd_f;
                    case (funct)
                        FN_ADD:  d_op = EXE_ADD_OP;
                        FN_SUB:  d_op = EXE_SUB_OP;
                        FN_AND:  d_op = EXE_AND_OP;
                        FN_OR:   d_op = EXE_OR_OP;
                        FN_XOR:  d_op = EXE_XOR_OP;
                        FN_NOR:  d_op = EXE_NOR_OP;
                        FN_SLT:  d_op = EXE_SLT_OP;
                        default: begin
                            d_wreg    = 1'b0;
                            d_waddr   = 5'd0;
                            d_illegal = 1'b1;
                        end
                    endcase
                end
                OPC_ADDI: begin
                    d_op = EXE_ADDI_OP; d_b = sext;
                    d_wreg = 1'b1; d_waddr = rt_f;
                end
                OPC_ANDI: begin
                    d_op = EXE_ANDI_OP; d_b = zext;
                    d_wreg = 1'b1; d_waddr = rt_f;
                end
                OPC_ORI: begin
                    d_op = EXE_ORI_OP; d_b = zext;
                    d_wreg = 1'b1; d_waddr = rt_f;
                end
                OPC_XORI: begin
                    d_op = EXE_XORI_OP; d_b = zext;
                    d_wreg = 1'b1; d_waddr = rt_f;
                end
                OPC_LUI: begin
                    d_op = EXE_LUI_OP; d_b = zext;
                    d_wreg = 1'b1; d_waddr = rt_f;
                end
                OPC_LW: begin
                    d_op = EXE_LW_OP; d_b = sext;
                    d_wreg = 1'b1; d_waddr = rt_f;
                end
                OPC_SW: begin
                    d_op = EXE_SW_OP; d_b = sext;
                    d_waddr = rt_f;
                end
                OPC_BEQ: begin
                    d_op = EXE_BEQ_OP;
                    d_waddr = rt_f;
                end
                default: d_illegal = 1'b1;
            endcase
            // $0 is hardwired: never request a write to it
            if (d_waddr == 5'd0)
                d_wreg = 1'b0;
        end
    end

    logic accept;

    assign in_ready = !rst && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            op        <= 8'd0;
            a         <= 32'd0;
            b         <= 32'd0;
            wreg      <= 1'b0;
            waddr     <= 5'd0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            wreg      <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            op        <= d_op;
            a         <= d_a;
            b         <= d_b;
            wreg      <= d_wreg;
            waddr     <= d_waddr;
            illegal   <= d_illegal;
        end else if (out_ready) begin
            // drained: payload stays for debug, only the write enable drops
            out_valid <= 1'b0;
            wreg      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_dec.sv
// Self-checking bench for alu_issue_dec: directed vector table, handshake
// corner sequences, and randomized traffic against a reference model.
module tb_alu_issue_dec;

    localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
    localparam logic [7:0] EXE_ANDI_OP = 8'b01011001;
    localparam logic [7:0] EXE_ORI_OP  = 8'b01011010;
    localparam logic [7:0] EXE_XORI_OP = 8'b01011011;
    localparam logic [7:0] EXE_LUI_OP  = 8'b01011100;
    localparam logic [7:0] EXE_SLT_OP  = 8'b00101010;
    localparam logic [7:0] EXE_ADD_OP  = 8'b00100000;
    localparam logic [7:0] EXE_SUB_OP  = 8'b00100010;
    localparam logic [7:0] EXE_ADDI_OP = 8'b01010101;
    localparam logic [7:0] EXE_BEQ_OP  = 8'b01010001;
    localparam logic [7:0] EXE_LW_OP   = 8'b11100011;
    localparam logic [7:0] EXE_SW_OP   = 8'b11101011;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        wreg;
    logic [4:0]  waddr;
    logic        illegal;

    alu_issue_dec #(.IMM_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .op(op), .a(a), .b(b),
        .wreg(wreg), .waddr(waddr), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        wreg;
        logic [4:0]  waddr;
        logic        ill;
    } dec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        dec_t        exp;
    } vec_t;

    // Reference decoder written straight from the instruction table.
    function automatic dec_t ref_dec(input logic [31:0] i,
                                     input logic [31:0] rs,
                                     input logic [31:0] rt);
        dec_t d;
        logic [31:0] se;
        logic [31:0] ze;
        int opc;
        int fn;
        opc = int'(i[31:26]);
        fn  = int'(i[5:0]);
        se  = 32'(signed'(i[15:0]));
        ze  = 32'(i[15:0]);
        d.op = 8'd0; d.a = rs; d.b = rt;
        d.wreg = 1'b0; d.waddr = 5'd0; d.ill = 1'b0;
        if (i == 32'd0) return d;
        if (opc == 0) begin
            d.wreg = 1'b1;
            d.waddr = i[15:11];
            case (fn)
                32: d.op = EXE_ADD_OP;
                34: d.op = EXE_SUB_OP;
                36: d.op = EXE_AND_OP;
                37: d.op = EXE_OR_OP;
                38: d.op = EXE_XOR_OP;
                39: d.op = EXE_NOR_OP;
                42: d.op = EXE_SLT_OP;
                default: begin
                    d.ill = 1'b1; d.wreg = 1'b0; d.waddr = 5'd0;
                end
            endcase
        end else begin
            d.waddr = i[20:16];
            d.wreg = 1'b1;
            case (opc)
                8:  begin d.op = EXE_ADDI_OP; d.b = se; end
                12: begin d.op = EXE_ANDI_OP; d.b = ze; end
                13: begin d.op = EXE_ORI_OP;  d.b = ze; end
                14: begin d.op = EXE_XORI_OP; d.b = ze; end
                15: begin d.op = EXE_LUI_OP;  d.b = ze; end
                35: begin d.op = EXE_LW_OP;   d.b = se; end
                43: begin d.op = EXE_SW_OP;   d.b = se; d.wreg = 1'b0; end
                4:  begin d.op = EXE_BEQ_OP;  d.wreg = 1'b0; end
                default: begin
                    d.ill = 1'b1; d.wreg = 1'b0; d.waddr = 5'd0;
                end
            endcase
        end
        if (d.waddr == 5'd0) d.wreg = 1'b0;
        return d;
    endfunction

    task automatic check_out(input string tag, input logic v, input dec_t e);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".op"}, 32'(op), 32'(e.op));
        check({tag, ".a"}, a, e.a);
        check({tag, ".b"}, b, e.b);
        check({tag, ".wreg"}, 32'(wreg), 32'(e.wreg));
        check({tag, ".waddr"}, 32'(waddr), 32'(e.waddr));
        check({tag, ".illegal"}, 32'(illegal), 32'(e.ill));
    endtask

    function automatic vec_t mk(input logic [31:0] i, input logic [31:0] rs,
                                input logic [31:0] rt, input logic [7:0] o,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input logic w, input logic [4:0] wa,
                                input logic il);
        vec_t v;
        v.instr = i; v.rs = rs; v.rt = rt;
        v.exp.op = o; v.exp.a = ea; v.exp.b = eb;
        v.exp.wreg = w; v.exp.waddr = wa; v.exp.ill = il;
        return v;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int sel;
        int fns[8];
        int opcs[9];
        fns  = '{32, 34, 36, 37, 38, 39, 42, 1};
        opcs = '{8, 12, 13, 14, 15, 35, 43, 4, 63};
        r = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 4) begin
            r[31:26] = 6'd0;
            r[5:0] = 6'(fns[$urandom_range(0, 7)]);
            if ($urandom_range(0, 7) == 0) r[15:11] = 5'd0;
        end else if (sel < 9) begin
            r[31:26] = 6'(opcs[$urandom_range(0, 8)]);
            if ($urandom_range(0, 7) == 0) r[20:16] = 5'd0;
        end else begin
            r = 32'd0;
        end
        return r;
    endfunction

    vec_t vecs[$];
    dec_t e;
    dec_t m;
    logic m_valid;
    logic exp_rdy;

    initial begin
        rst = 1'b1; in_valid = 1'b0; instr = 32'd0;
        rs_data = 32'd0; rt_data = 32'd0; flush = 1'b0; out_ready = 1'b0;

        vecs.push_back(mk(32'h01095020, 5, 7, EXE_ADD_OP, 5, 7, 1, 10, 0));
        vecs.push_back(mk(32'h2128FFFF, 3, 9, EXE_ADDI_OP, 3,
                          32'hFFFFFFFF, 1, 8, 0));
        vecs.push_back(mk(32'h3528FFFF, 3, 9, EXE_ORI_OP, 3,
                          32'h0000FFFF, 1, 8, 0));
        vecs.push_back(mk(32'hAD090004, 32'h11, 32'h22, EXE_SW_OP, 32'h11,
                          4, 0, 9, 0));
        vecs.push_back(mk(32'h00004020, 32'h11, 32'h22, EXE_ADD_OP, 32'h11,
                          32'h22, 1, 8, 0));
        vecs.push_back(mk(32'h00000020, 32'h11, 32'h22, EXE_ADD_OP, 32'h11,
                          32'h22, 0, 0, 0));
        vecs.push_back(mk(32'h00000000, 32'h11, 32'h22, 8'd0, 32'h11,
                          32'h22, 0, 0, 0));
        vecs.push_back(mk(32'h3C081234, 32'h11, 32'h22, EXE_LUI_OP, 32'h11,
                          32'h1234, 1, 8, 0));
        vecs.push_back(mk(32'h11090010, 32'h11, 32'h22, EXE_BEQ_OP, 32'h11,
                          32'h22, 0, 9, 0));
        vecs.push_back(mk(32'h0109502A, 32'h11, 32'h22, EXE_SLT_OP, 32'h11,
                          32'h22, 1, 10, 0));
        vecs.push_back(mk(32'h01095027, 32'h11, 32'h22, EXE_NOR_OP, 32'h11,
                          32'h22, 1, 10, 0));
        vecs.push_back(mk(32'h8D09FFF0, 32'h11, 32'h22, EXE_LW_OP, 32'h11,
                          32'hFFFFFFF0, 1, 9, 0));
        vecs.push_back(mk(32'h01095022, 32'h11, 32'h22, EXE_SUB_OP, 32'h11,
                          32'h22, 1, 10, 0));
        vecs.push_back(mk(32'h3128F00F, 32'h11, 32'h22, EXE_ANDI_OP, 32'h11,
                          32'h0000F00F, 1, 8, 0));
        vecs.push_back(mk(32'hFC000000, 32'h11, 32'h22, 8'd0, 32'h11,
                          32'h22, 0, 0, 1));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", 32'(in_ready), 0);
        e = '{op: 8'd0, a: 0, b: 0, wreg: 0, waddr: 0, ill: 0};
        check_out("rst", 1'b0, e);
        rst = 1'b0;

        // directed vector table, one accept per cycle, out_ready held high
        foreach (vecs[k]) begin
            in_valid = 1'b1; out_ready = 1'b1;
            instr = vecs[k].instr;
            rs_data = vecs[k].rs; rt_data = vecs[k].rt;
            #1;
            check($sformatf("vec%0d.in_ready", k), 32'(in_ready), 1);
            @(posedge clk); #1;
            check_out($sformatf("vec%0d", k), 1'b1, vecs[k].exp);
        end

        // hold: 3 stalled cycles, then release with no bubble
        instr = 32'h01095020; rs_data = 32'hA; rt_data = 32'hB;
        @(posedge clk); #1;
        out_ready = 1'b0;
        instr = 32'h3528FFFF; rs_data = 32'hC;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("hold%0d.in_ready", c), 32'(in_ready), 0);
            @(posedge clk); #1;
            check($sformatf("hold%0d.valid", c), 32'(out_valid), 1);
            check($sformatf("hold%0d.op", c), 32'(op), 32'(EXE_ADD_OP));
            check($sformatf("hold%0d.a", c), a, 32'hA);
        end
        out_ready = 1'b1;
        #1;
        check("release.in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        check("release.op", 32'(op), 32'(EXE_ORI_OP));
        check("release.a", a, 32'hC);

        // flush with a pending input: nothing accepted, entry dropped
        out_ready = 1'b0; flush = 1'b1;
        instr = 32'h01095022; rs_data = 32'hD;
        #1;
        check("flush.in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        check("flush.valid", 32'(out_valid), 0);
        check("flush.wreg", 32'(wreg), 0);
        check("flush.op", 32'(op), 32'(EXE_ORI_OP));
        flush = 1'b0;
        #1;
        check("postflush.in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        check("postflush.valid", 32'(out_valid), 1);
        check("postflush.op", 32'(op), 32'(EXE_SUB_OP));

        // drain: valid and wreg drop, payload kept
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("drain.valid", 32'(out_valid), 0);
        check("drain.wreg", 32'(wreg), 0);
        check("drain.op", 32'(op), 32'(EXE_SUB_OP));

        // async reset mid-cycle drops a held illegal entry
        in_valid = 1'b1; instr = 32'hFC000000;
        @(posedge clk); #1;
        check("ill.illegal", 32'(illegal), 1);
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst.valid", 32'(out_valid), 0);
        check("arst.illegal", 32'(illegal), 0);
        check("arst.in_ready", 32'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;

        // randomized traffic against the reference model
        m_valid = 1'b0;
        m = '{op: 8'd0, a: 0, b: 0, wreg: 0, waddr: 0, ill: 0};
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 11) == 0);
            instr     = rand_instr();
            rs_data   = $urandom;
            rt_data   = $urandom;
            @(negedge clk);
            exp_rdy = !flush && (!m_valid || out_ready);
            check($sformatf("rnd%0d.in_ready", n), 32'(in_ready),
                  32'(exp_rdy));
            check_out($sformatf("rnd%0d", n), m_valid, m);
            if (flush) begin
                m_valid = 1'b0; m.wreg = 1'b0;
            end else if (in_valid && exp_rdy) begin
                m_valid = 1'b1; m = ref_dec(instr, rs_data, rt_data);
            end else if (out_ready) begin
                m_valid = 1'b0; m.wreg = 1'b0;
            end
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
